// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Types and constants shared by the hazard, forwarding and
//               stall control logic of the 5-stage CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Miss-wait FSM state encoding
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } hz_state_e;

    // Architectural zero register; writes to it are discarded, so it never
    // creates a true data dependence.
    localparam logic [4:0] C_REG_X0 = 5'd0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               Synchronous clear, asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] C_MAX = '1;

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: clear wins, otherwise increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != C_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Stall/flush controller for the 5-stage pipeline. Resolves
//               load-use hazards with a single bubble, freezes the whole
//               pipeline during data-cache misses, flushes IF/ID on taken
//               branches, watches for runaway misses and counts events.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_RS1_i,
    input  logic [4:0]       ID_RS2_i,
    input  logic             ID_UseRS2_i,
    input  logic [4:0]       EX_Rd_i,
    input  logic             EX_MemRead_i,
    input  logic             ID_BranchTaken_i,
    input  logic             Dcache_Stall_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Nop_o,
    output logic             Back_Write_o,
    output logic             Timeout_o,
    output logic [CNT_W-1:0] Stall_Cnt_o,
    output logic [CNT_W-1:0] Bubble_Cnt_o,
    output logic [CNT_W-1:0] Flush_Cnt_o
);

    // One extra bit so the counter can sit past MISS_TIMEOUT-1 without wrapping
    localparam int                ML_W    = $clog2(MISS_TIMEOUT) + 1;
    localparam logic [ML_W-1:0]   C_ML_HIT = ML_W'(MISS_TIMEOUT - 1);
    localparam logic [ML_W-1:0]   C_ML_MAX = '1;

    hz_state_e         state_d;
    hz_state_e         state_q;
    logic [ML_W-1:0]   miss_len_d;
    logic [ML_W-1:0]   miss_len_q;
    logic              timeout_d;
    logic              timeout_q;

    logic              w_load_use;
    logic              w_freeze;
    logic              w_timeout_hit;

    // Load-use: EX holds a load whose (non-x0) destination is read in ID
    always_comb begin
        w_load_use = EX_MemRead_i
                  && (EX_Rd_i != C_REG_X0)
                  && ((EX_Rd_i == ID_RS1_i)
                      || (ID_UseRS2_i && (EX_Rd_i == ID_RS2_i)));
    end

    // Pipeline control decode: freeze > load-use bubble > branch flush > run.
    // The raw stall input is included so the freeze starts in the very cycle
    // the cache raises it, before the FSM has registered MISS.
    always_comb begin
        w_freeze      = (state_q == ST_MISS) || Dcache_Stall_i;
        PC_Write_o    = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_ID_Flush_o = 1'b0;
        ID_EX_Nop_o   = 1'b0;
        Back_Write_o  = 1'b1;
        if (w_freeze) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            Back_Write_o  = 1'b0;
        end else if (w_load_use) begin
            // A branch resolved alongside the bubble is re-evaluated next cycle
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            ID_EX_Nop_o   = 1'b1;
        end else if (ID_BranchTaken_i) begin
            IF_ID_Flush_o = 1'b1;
        end
    end

    // Miss-wait FSM next state: enter MISS on a stall, leave on the first
    // stall-free cycle (that cycle itself is still frozen via state_q)
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (Dcache_Stall_i)  state_d = ST_MISS;
            ST_MISS: if (!Dcache_Stall_i) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Watchdog: length of the current MISS residency, plus sticky error.
    // The error is visible in the same cycle the limit is reached.
    always_comb begin
        w_timeout_hit = (state_q == ST_MISS) && (miss_len_q == C_ML_HIT);
        miss_len_d    = miss_len_q;
        if (state_q == ST_RUN) begin
            miss_len_d = '0;
        end else if (miss_len_q != C_ML_MAX) begin
            miss_len_d = miss_len_q + 1'b1;
        end
        timeout_d = timeout_q || w_timeout_hit;
    end

    // FSM and watchdog registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            miss_len_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            miss_len_q <= miss_len_d;
            timeout_q  <= timeout_d;
        end
    end

    assign Timeout_o = timeout_q || w_timeout_hit;

    // Performance counters
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (state_q == ST_MISS),
        .clear_i (1'b0),
        .count_o (Stall_Cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (ID_EX_Nop_o),
        .clear_i (1'b0),
        .count_o (Bubble_Cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (IF_ID_Flush_o),
        .clear_i (1'b0),
        .count_o (Flush_Cnt_o)
    );

endmodule : hazard_stall_ctrl
`default_nettype wire
